// File: rtl/gp_cr_regfile.sv
// gp_cr_regfile: decode-stage register storage.
//   - 32x32 general-purpose register file (r0 hardwired to zero), two write ports.
//   - 32x32 control register file (all entries writable), one write port.
//   - Registered read data (1-cycle latency) aligned with the decode->execute
//     boundary, with same-cycle write bypass; reads hold while stall is high.
//
// Ports:
//   clk, rst (sync, active-high), stall (holds d_1/d_2/cd)
//   s_1/d_1, s_2/d_2           : GPR read ports (address in, registered data out)
//   we1/target_1/write_data_1  : GPR write port 1 (load result, wins on conflict)
//   we2/target_2/write_data_2  : GPR write port 2 (base-register increment)
//   cs/cd                      : CR read port (registered data out)
//   cwe/ctgt/cwrite_data       : CR write port
//   ret_val                    : live contents of r1, straight from storage
module gp_cr_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [4:0]  s_1,
   output logic [31:0] d_1,
   input  logic [4:0]  s_2,
   output logic [31:0] d_2,
   input  logic        we1,
   input  logic [4:0]  target_1,
   input  logic [31:0] write_data_1,
   input  logic        we2,
   input  logic [4:0]  target_2,
   input  logic [31:0] write_data_2,
   input  logic [4:0]  cs,
   output logic [31:0] cd,
   input  logic        cwe,
   input  logic [4:0]  ctgt,
   input  logic [31:0] cwrite_data,
   output logic [31:0] ret_val
);

   logic [31:0] gpr [32];
   logic [31:0] cr  [32];

   logic [31:0] d_1_nxt;
   logic [31:0] d_2_nxt;
   logic [31:0] cd_nxt;

   // Read-side bypass: a write landing on the same edge as the read sample
   // is forwarded, port 1 taking priority. Address 0 short-circuits to zero
   // so a discarded r0 write never leaks through the bypass.
   always_comb begin
      d_1_nxt = gpr[s_1];
      if (s_1 == 5'd0)
         d_1_nxt = '0;
      else if (we1 && (target_1 == s_1))
         d_1_nxt = write_data_1;
      else if (we2 && (target_2 == s_1))
         d_1_nxt = write_data_2;

      d_2_nxt = gpr[s_2];
      if (s_2 == 5'd0)
         d_2_nxt = '0;
      else if (we1 && (target_1 == s_2))
         d_2_nxt = write_data_1;
      else if (we2 && (target_2 == s_2))
         d_2_nxt = write_data_2;

      cd_nxt = cr[cs];
      if (cwe && (ctgt == cs))
         cd_nxt = cwrite_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < 32; i++) begin
            gpr[i] <= '0;
            cr[i]  <= '0;
         end
         d_1 <= '0;
         d_2 <= '0;
         cd  <= '0;
      end else begin
         // Port 2 is assigned first so a same-address port 1 write overrides it.
         if (we2 && (target_2 != 5'd0))
            gpr[target_2] <= write_data_2;
         if (we1 && (target_1 != 5'd0))
            gpr[target_1] <= write_data_1;
         if (cwe)
            cr[ctgt] <= cwrite_data;
         // Writeback proceeds during stall; only the read registers hold.
         if (!stall) begin
            d_1 <= d_1_nxt;
            d_2 <= d_2_nxt;
            cd  <= cd_nxt;
         end
      end
   end

   always_comb begin
      ret_val = gpr[1];
   end

endmodule

// File: tb/tb_gp_cr_regfile.sv
module tb_gp_cr_regfile;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [4:0]  s_1;
  logic [31:0] d_1;
  logic [4:0]  s_2;
  logic [31:0] d_2;
  logic        we1;
  logic [4:0]  target_1;
  logic [31:0] write_data_1;
  logic        we2;
  logic [4:0]  target_2;
  logic [31:0] write_data_2;
  logic [4:0]  cs;
  logic [31:0] cd;
  logic        cwe;
  logic [4:0]  ctgt;
  logic [31:0] cwrite_data;
  logic [31:0] ret_val;

  gp_cr_regfile dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .s_1          (s_1),
    .d_1          (d_1),
    .s_2          (s_2),
    .d_2          (d_2),
    .we1          (we1),
    .target_1     (target_1),
    .write_data_1 (write_data_1),
    .we2          (we2),
    .target_2     (target_2),
    .write_data_2 (write_data_2),
    .cs           (cs),
    .cd           (cd),
    .cwe          (cwe),
    .ctgt         (ctgt),
    .cwrite_data  (cwrite_data),
    .ret_val      (ret_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int SEL_D1  = 0;
  localparam int SEL_D2  = 1;
  localparam int SEL_CD  = 2;
  localparam int SEL_RET = 3;

  typedef struct {
    int          tag;
    int          sel;
    logic [31:0] exp;
    int          id;
  } item_t;

  item_t sb[$];
  int    vectors     = 0;
  int    miscompares = 0;
  int    next_id     = 0;

  function automatic string sel_name(input int sel);
    case (sel)
      SEL_D1:  return "d_1";
      SEL_D2:  return "d_2";
      SEL_CD:  return "cd";
      default: return "ret_val";
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].tag <= cyc) begin
      item_t it;
      logic [31:0] act;
      it = sb.pop_front();
      case (it.sel)
        SEL_D1:  act = d_1;
        SEL_D2:  act = d_2;
        SEL_CD:  act = cd;
        default: act = ret_val;
      endcase
      vectors++;
      if (it.tag != cyc || act !== it.exp) begin
        miscompares++;
        $display("FAIL vec%0d %s: got 0x%08h expected 0x%08h (edge %0d, due %0d)",
                 it.id, sel_name(it.sel), act, it.exp, cyc, it.tag);
      end
    end
  end

  task automatic expect_out(input int sel, input logic [31:0] v);
    item_t it;
    it.tag = cyc + 1;
    it.sel = sel;
    it.exp = v;
    it.id  = next_id;
    next_id++;
    sb.push_back(it);
  endtask

  task automatic quiet();
    rst = 1'b0; stall = 1'b0;
    we1 = 1'b0; we2 = 1'b0; cwe = 1'b0;
  endtask

  task automatic wr1(input logic [4:0] a, input logic [31:0] v);
    we1 = 1'b1; target_1 = a; write_data_1 = v;
  endtask

  task automatic wr2(input logic [4:0] a, input logic [31:0] v);
    we2 = 1'b1; target_2 = a; write_data_2 = v;
  endtask

  task automatic cwr(input logic [4:0] a, input logic [31:0] v);
    cwe = 1'b1; ctgt = a; cwrite_data = v;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0;
    s_1 = '0; s_2 = '0; cs = '0;
    we1 = 1'b0; target_1 = '0; write_data_1 = '0;
    we2 = 1'b0; target_2 = '0; write_data_2 = '0;
    cwe = 1'b0; ctgt = '0; cwrite_data = '0;
    @(negedge clk);

    rst = 1'b1;
    expect_out(SEL_D1, 32'h0); expect_out(SEL_D2, 32'h0);
    expect_out(SEL_CD, 32'h0); expect_out(SEL_RET, 32'h0);
    tick();

    quiet();
    for (int i = 0; i < 32; i++) begin
      s_1 = 5'(i); s_2 = 5'(31 - i); cs = 5'(i);
      expect_out(SEL_D1, 32'h0); expect_out(SEL_D2, 32'h0); expect_out(SEL_CD, 32'h0);
      tick();
    end
    expect_out(SEL_RET, 32'h0);
    tick();

    quiet(); s_1 = 5'd0; wr1(5'd5, 32'hDEADBEEF);
    tick();
    quiet(); s_1 = 5'd5;
    expect_out(SEL_D1, 32'hDEADBEEF);
    tick();
    vectors++;
    if (d_1 !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL direct d_1: got 0x%08h expected 0xDEADBEEF", d_1);
    end

    quiet(); wr1(5'd1, 32'h0000_1234);
    expect_out(SEL_RET, 32'h0000_1234);
    tick();
    vectors++;
    if (ret_val !== 32'h0000_1234) begin
      miscompares++;
      $display("FAIL direct ret_val: got 0x%08h expected 0x00001234", ret_val);
    end
    quiet();
    expect_out(SEL_RET, 32'h0000_1234);
    tick();

    quiet(); wr1(5'd0, 32'hFFFF_FFFF); wr2(5'd0, 32'h1); s_1 = 5'd0; s_2 = 5'd0;
    expect_out(SEL_D1, 32'h0); expect_out(SEL_D2, 32'h0);
    tick();
    vectors++;
    if (d_1 !== 32'h0 || d_2 !== 32'h0) begin
      miscompares++;
      $display("FAIL direct r0: d_1=0x%08h d_2=0x%08h expected 0", d_1, d_2);
    end
    quiet();
    expect_out(SEL_D1, 32'h0); expect_out(SEL_D2, 32'h0);
    tick();

    quiet(); wr1(5'd7, 32'hAAAA); wr2(5'd7, 32'hBBBB); s_1 = 5'd7; s_2 = 5'd7;
    expect_out(SEL_D1, 32'hAAAA); expect_out(SEL_D2, 32'hAAAA);
    tick();
    vectors++;
    if (d_1 !== 32'hAAAA) begin
      miscompares++;
      $display("FAIL direct priority d_1: got 0x%08h expected 0x0000AAAA", d_1);
    end
    quiet(); s_1 = 5'd5; s_2 = 5'd7;
    expect_out(SEL_D1, 32'hDEADBEEF); expect_out(SEL_D2, 32'hAAAA);
    tick();

    quiet(); wr2(5'd9, 32'h55); s_1 = 5'd9; s_2 = 5'd9;
    expect_out(SEL_D1, 32'h55); expect_out(SEL_D2, 32'h55);
    tick();
    vectors++;
    if (d_2 !== 32'h55) begin
      miscompares++;
      $display("FAIL direct port2 bypass d_2: got 0x%08h expected 0x00000055", d_2);
    end
    quiet(); wr1(5'd10, 32'h77); wr2(5'd11, 32'h66); s_1 = 5'd11; s_2 = 5'd10;
    expect_out(SEL_D1, 32'h66); expect_out(SEL_D2, 32'h77);
    tick();

    quiet(); cwr(5'd0, 32'h8); cs = 5'd0;
    expect_out(SEL_CD, 32'h8);
    tick();
    quiet(); cwr(5'd4, 32'hC0DE); cs = 5'd0;
    expect_out(SEL_CD, 32'h8);
    tick();
    quiet(); cs = 5'd4;
    expect_out(SEL_CD, 32'hC0DE);
    tick();
    vectors++;
    if (cd !== 32'hC0DE) begin
      miscompares++;
      $display("FAIL direct cd: got 0x%08h expected 0x0000C0DE", cd);
    end

    quiet(); wr1(5'd3, 32'h10);
    tick();
    quiet(); s_1 = 5'd3; cs = 5'd4;
    expect_out(SEL_D1, 32'h10); expect_out(SEL_CD, 32'hC0DE);
    tick();
    quiet(); stall = 1'b1; s_1 = 5'd5; cs = 5'd0; wr1(5'd3, 32'h20); cwr(5'd4, 32'h1);
    expect_out(SEL_D1, 32'h10); expect_out(SEL_CD, 32'hC0DE);
    tick();
    quiet(); stall = 1'b1; s_1 = 5'd7;
    expect_out(SEL_D1, 32'h10);
    tick();
    quiet(); stall = 1'b1; s_1 = 5'd0;
    expect_out(SEL_D1, 32'h10); expect_out(SEL_CD, 32'hC0DE);
    tick();
    vectors++;
    if (d_1 !== 32'h10) begin
      miscompares++;
      $display("FAIL direct stall hold d_1: got 0x%08h expected 0x00000010", d_1);
    end
    quiet(); s_1 = 5'd3; cs = 5'd4;
    expect_out(SEL_D1, 32'h20); expect_out(SEL_CD, 32'h1);
    tick();
    vectors++;
    if (d_1 !== 32'h20) begin
      miscompares++;
      $display("FAIL direct post-stall d_1: got 0x%08h expected 0x00000020", d_1);
    end

    quiet(); rst = 1'b1; stall = 1'b1; wr1(5'd1, 32'h9999); cwr(5'd4, 32'hFFFF);
    expect_out(SEL_D1, 32'h0); expect_out(SEL_D2, 32'h0);
    expect_out(SEL_CD, 32'h0); expect_out(SEL_RET, 32'h0);
    tick();
    vectors++;
    if (cd !== 32'h0 || ret_val !== 32'h0) begin
      miscompares++;
      $display("FAIL direct reset: cd=0x%08h ret_val=0x%08h expected 0", cd, ret_val);
    end
    quiet(); s_1 = 5'd1; s_2 = 5'd7; cs = 5'd4;
    expect_out(SEL_D1, 32'h0); expect_out(SEL_D2, 32'h0);
    expect_out(SEL_CD, 32'h0); expect_out(SEL_RET, 32'h0);
    tick();

    quiet();
    for (int k = 0; k < 10 && sb.size() > 0; k++) tick();
    while (sb.size() > 0) begin
      item_t it;
      it = sb.pop_front();
      vectors++;
      miscompares++;
      $display("FAIL vec%0d %s: never checked, expected 0x%08h", it.id, sel_name(it.sel), it.exp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
